// File: rtl/xor_cipher_pkg.sv
// Shared sizing, the decrypt FSM state encoding and a counter-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xor_cipher_pkg;

    // Default frame length and key width; the frame must hold a whole number of keys.
    localparam int MSG_SIZE_DEF   = 64;
    localparam int KEY_SIZE_DEF   = 8;
    localparam int NUM_CHUNKS_DEF = MSG_SIZE_DEF / KEY_SIZE_DEF;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_DECRYPT = 3'd2,
        ST_DONE    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel front end: shift register, bit counter, flag edge detect, frame checks.
// Latency: one bit per enabled clock; status strobes are combinational on the current inputs.
// Backpressure: none; ena=0 freezes every register so a paused frame resumes intact.
module serial_frame_rx
    import xor_cipher_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int CNT_W    = cnt_width(MSG_SIZE_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                data_in,
    input  logic                flag_in,
    input  logic                in_idle,
    input  logic                in_recv,
    output logic                frame_start,
    output logic                frame_done,
    output logic                short_err,
    output logic                overrun_err,
    output logic [MSG_SIZE-1:0] shift_dat,
    output logic [CNT_W-1:0]    bit_cnt
);

    logic                flag_dly_q, flag_dly_d;
    logic [MSG_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full;
    logic                take_bit;

    // Detect frame boundaries and decide whether this cycle's bit is captured.
    always_comb begin
        flag_dly_d  = ena ? flag_in : flag_dly_q;
        full        = (cnt_q == CNT_W'(MSG_SIZE));
        // A frame only opens on a fresh rising flag edge while the FSM is idle.
        frame_start = ena & in_idle & flag_in & ~flag_dly_q;
        frame_done  = ena & in_recv & ~flag_in & full;
        short_err   = ena & in_recv & ~flag_in & ~full;
        overrun_err = ena & in_recv & flag_in & full;
        take_bit    = ena & in_recv & flag_in & ~full;

        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (frame_start) begin
            shift_d = {shift_q[MSG_SIZE-2:0], data_in};
            cnt_d   = CNT_W'(1);
        end else if (take_bit) begin
            shift_d = {shift_q[MSG_SIZE-2:0], data_in};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Receive-side state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_dly_q <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
        end else begin
            flag_dly_q <= flag_dly_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
        end
    end

    assign shift_dat = shift_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: rtl/xor_stream_decryptor.sv
// Rebuilds a serial ciphertext frame and XOR-decrypts it one key-width chunk per cycle.
// Latency: oValid rises NUM_CHUNKS+1 enabled clocks after the edge that sees the flag drop.
// Backpressure: none; ena=0 holds all state, bits arriving while decrypting flag an error.
module xor_stream_decryptor
    import xor_cipher_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int KEY_SIZE = KEY_SIZE_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic                             iData_in,
    input  logic                             iData_flag,
    input  logic [KEY_SIZE-1:0]              iKey,
    output logic [MSG_SIZE-1:0]              oPlaintext,
    output logic                             oValid,
    output logic                             oBusy,
    output logic                             oFrame_error,
    output logic [cnt_width(MSG_SIZE)-1:0]   oBit_counter
);

    localparam int NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
    localparam int CNT_W      = cnt_width(MSG_SIZE);
    localparam int CIDX_W     = cnt_width(NUM_CHUNKS);

    state_t              state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [MSG_SIZE-1:0] work_q, work_d;
    logic [MSG_SIZE-1:0] plain_q, plain_d;
    logic [CIDX_W-1:0]   chunk_q, chunk_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                frame_start;
    logic                frame_done;
    logic                short_err;
    logic                overrun_err;
    logic [MSG_SIZE-1:0] shift_dat;
    logic [CNT_W-1:0]    bit_cnt;

    serial_frame_rx #(
        .MSG_SIZE (MSG_SIZE),
        .CNT_W    (CNT_W)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .data_in     (iData_in),
        .flag_in     (iData_flag),
        .in_idle     (state_q == ST_IDLE),
        .in_recv     (state_q == ST_RECV),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .short_err   (short_err),
        .overrun_err (overrun_err),
        .shift_dat   (shift_dat),
        .bit_cnt     (bit_cnt)
    );

    // Frame FSM and chunked XOR; every output is computed here and registered below.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        work_d  = work_q;
        plain_d = plain_q;
        chunk_d = chunk_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (ena) begin
            valid_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        key_d   = iKey;
                        err_d   = 1'b0;
                        state_d = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (frame_done) begin
                        chunk_d = '0;
                        state_d = ST_DECRYPT;
                    end else if (short_err) begin
                        // Short frame: discard, keep the last good plaintext.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (overrun_err) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DECRYPT: begin
                    // Bits arriving now are dropped, but the frame in hand still completes.
                    if (iData_flag) begin
                        err_d = 1'b1;
                    end
                    if (chunk_q < CIDX_W'(NUM_CHUNKS)) begin
                        // Chunk 0 is the most significant key-width slice.
                        for (int c = 0; c < NUM_CHUNKS; c++) begin
                            if (chunk_q == CIDX_W'(c)) begin
                                work_d[MSG_SIZE-1-c*KEY_SIZE -: KEY_SIZE] =
                                    shift_dat[MSG_SIZE-1-c*KEY_SIZE -: KEY_SIZE] ^ key_q;
                            end
                        end
                        chunk_d = chunk_q + CIDX_W'(1);
                    end else begin
                        plain_d = work_q;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (iData_flag) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                ST_DRAIN: begin
                    // Swallow the rest of an overlong frame before listening again.
                    if (!iData_flag) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // All FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            work_q  <= '0;
            plain_q <= '0;
            chunk_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            work_q  <= work_d;
            plain_q <= plain_d;
            chunk_q <= chunk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign oPlaintext   = plain_q;
    assign oValid       = valid_q;
    assign oBusy        = busy_q;
    assign oFrame_error = err_q;
    assign oBit_counter = bit_cnt;

endmodule
